// File: rtl/axi_lite_reg_slv.sv
// -----------------------------------------------------------------------------
// axi_lite_reg_slv
// AXI4-Lite responder that terminates single-beat reads and writes into a bank
// of word-wide registers. Read-write words live here, are byte-strobe
// updatable and are exported to the peripheral. Read-only words are taken
// from hardware inputs.
//
// Ports:
//   clk_i       clock, all state on the rising edge
//   rst_i       asynchronous, active-high reset
//   slv_req_i   AXI4-Lite request from the initiator
//   slv_resp_o  AXI4-Lite response to the initiator
//   reg_q_o     current RW register values (0 for read-only indices)
//   reg_wr_o    one-cycle pulse per register updated by a write
//   ro_d_i      read values for read-only registers
// -----------------------------------------------------------------------------

// Default 32-bit address / 32-bit data AXI4-Lite channel types.
package axi_lite_reg_slv_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
    } ax_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } w_chan_t;

    typedef struct packed {
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        logic    ar_ready;
        r_chan_t r;
        logic    r_valid;
    } resp_t;
endpackage

module axi_lite_reg_slv #(
    parameter int unsigned                          NoRegs       = 16,
    parameter int unsigned                          AxiAddrWidth = 32,
    parameter int unsigned                          AxiDataWidth = 32,
    parameter logic [AxiAddrWidth-1:0]              BaseAddr     = '0,
    parameter logic [NoRegs-1:0]                    ReadOnly     = '0,
    parameter logic [NoRegs-1:0][AxiDataWidth-1:0]  RegRstVal    = '0,
    parameter type                                  axi_req_t    = axi_lite_reg_slv_pkg::req_t,
    parameter type                                  axi_resp_t   = axi_lite_reg_slv_pkg::resp_t
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  axi_req_t                               slv_req_i,
    output axi_resp_t                              slv_resp_o,
    output logic [NoRegs-1:0][AxiDataWidth-1:0]    reg_q_o,
    output logic [NoRegs-1:0]                      reg_wr_o,
    input  logic [NoRegs-1:0][AxiDataWidth-1:0]    ro_d_i
);

    localparam int unsigned WB      = AxiDataWidth / 8;
    localparam int unsigned OffBits = $clog2(WB);
    localparam int unsigned IdxW    = (NoRegs > 1) ? $clog2(NoRegs) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {W_IDLE, W_RESP} wr_state_e;
    typedef enum logic {R_IDLE, R_RESP} rd_state_e;

    wr_state_e r_wrState, w_wrStateNext;
    rd_state_e r_rdState, w_rdStateNext;

    logic [NoRegs-1:0][AxiDataWidth-1:0] r_regQ;
    logic [NoRegs-1:0]                   r_regWr;
    logic [1:0]                          r_bResp;
    logic [AxiDataWidth-1:0]             r_rData;
    logic [1:0]                          r_rResp;

    logic                    w_awReady, w_wReady, w_bValid, w_arReady, w_rValid;
    logic                    w_wrHs, w_rdHs;
    logic [AxiAddrWidth-1:0] w_wrWord, w_rdWord;
    logic                    w_wrHit, w_rdHit;
    logic [IdxW-1:0]         w_wrIdx, w_rdIdx;
    logic                    w_unused;

    // Protection bits carry no meaning for this register bank.
    assign w_unused = ^{slv_req_i.aw.prot, slv_req_i.ar.prot};

    // Address decode: word index relative to BaseAddr; the sub-word byte
    // offset bits fall away in the shift.
    assign w_wrWord = (slv_req_i.aw.addr - BaseAddr) >> OffBits;
    assign w_rdWord = (slv_req_i.ar.addr - BaseAddr) >> OffBits;
    assign w_wrHit  = (slv_req_i.aw.addr >= BaseAddr) && (w_wrWord < AxiAddrWidth'(NoRegs));
    assign w_rdHit  = (slv_req_i.ar.addr >= BaseAddr) && (w_rdWord < AxiAddrWidth'(NoRegs));
    assign w_wrIdx  = w_wrWord[IdxW-1:0];
    assign w_rdIdx  = w_rdWord[IdxW-1:0];

    assign w_wrHs = w_awReady && w_wReady;
    assign w_rdHs = w_arReady && slv_req_i.ar_valid;

    // Write FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_wrState <= W_IDLE;
        else       r_wrState <= w_wrStateNext;
    end

    // Write FSM next state: AW and W are only ever accepted together.
    always_comb begin
        w_wrStateNext = r_wrState;
        case (r_wrState)
            W_IDLE:  if (slv_req_i.aw_valid && slv_req_i.w_valid) w_wrStateNext = W_RESP;
            W_RESP:  if (slv_req_i.b_ready) w_wrStateNext = W_IDLE;
            default: w_wrStateNext = W_IDLE;
        endcase
    end

    // Write FSM outputs; readies are held low while reset is asserted.
    always_comb begin
        w_awReady = 1'b0;
        w_wReady  = 1'b0;
        w_bValid  = 1'b0;
        case (r_wrState)
            W_IDLE: begin
                w_awReady = slv_req_i.aw_valid && slv_req_i.w_valid && !rst_i;
                w_wReady  = slv_req_i.aw_valid && slv_req_i.w_valid && !rst_i;
            end
            W_RESP:  w_bValid = 1'b1;
            default: ;
        endcase
    end

    // Read FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_rdState <= R_IDLE;
        else       r_rdState <= w_rdStateNext;
    end

    // Read FSM next state.
    always_comb begin
        w_rdStateNext = r_rdState;
        case (r_rdState)
            R_IDLE:  if (slv_req_i.ar_valid) w_rdStateNext = R_RESP;
            R_RESP:  if (slv_req_i.r_ready) w_rdStateNext = R_IDLE;
            default: w_rdStateNext = R_IDLE;
        endcase
    end

    // Read FSM outputs.
    always_comb begin
        w_arReady = 1'b0;
        w_rValid  = 1'b0;
        case (r_rdState)
            R_IDLE:  w_arReady = !rst_i;
            R_RESP:  w_rValid  = 1'b1;
            default: ;
        endcase
    end

    // Register bank and write response. reg_wr_o pulses even for an
    // all-zero strobe, since the write still targeted that register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_regQ  <= RegRstVal;
            r_regWr <= '0;
            r_bResp <= '0;
        end else begin
            r_regWr <= '0;
            if (w_wrHs) begin
                if (!w_wrHit) begin
                    r_bResp <= RESP_DECERR;
                end else if (ReadOnly[w_wrIdx]) begin
                    r_bResp <= RESP_SLVERR;
                end else begin
                    r_bResp          <= RESP_OKAY;
                    r_regWr[w_wrIdx] <= 1'b1;
                    for (int b = 0; b < int'(WB); b++) begin
                        if (slv_req_i.w.strb[b])
                            r_regQ[w_wrIdx][8*b +: 8] <= slv_req_i.w.data[8*b +: 8];
                    end
                end
            end
        end
    end

    // Read data capture. r_regQ is sampled before any same-edge write lands,
    // so a concurrent read of the written register returns the old value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rData <= '0;
            r_rResp <= '0;
        end else if (w_rdHs) begin
            if (!w_rdHit) begin
                r_rData <= '0;
                r_rResp <= RESP_DECERR;
            end else if (ReadOnly[w_rdIdx]) begin
                r_rData <= ro_d_i[w_rdIdx];
                r_rResp <= RESP_OKAY;
            end else begin
                r_rData <= r_regQ[w_rdIdx];
                r_rResp <= RESP_OKAY;
            end
        end
    end

    // Exported register view; read-only slots are tied to zero.
    always_comb begin
        reg_q_o = '0;
        for (int k = 0; k < int'(NoRegs); k++) begin
            if (!ReadOnly[k]) reg_q_o[k] = r_regQ[k];
        end
    end

    assign reg_wr_o = r_regWr;

    always_comb begin
        slv_resp_o          = '0;
        slv_resp_o.aw_ready = w_awReady;
        slv_resp_o.w_ready  = w_wReady;
        slv_resp_o.b_valid  = w_bValid;
        slv_resp_o.b.resp   = r_bResp;
        slv_resp_o.ar_ready = w_arReady;
        slv_resp_o.r_valid  = w_rValid;
        slv_resp_o.r.data   = r_rData;
        slv_resp_o.r.resp   = r_rResp;
    end

endmodule

// File: tb/tb_axi_lite_reg_slv.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_reg_slv
// Self-checking bench for axi_lite_reg_slv: directed scenarios followed by a
// randomized mix of reads and writes, all compared against a register-array
// reference model that applies the decode/strobe/response rules directly.
// -----------------------------------------------------------------------------
module tb_axi_lite_reg_slv;
   import axi_lite_reg_slv_pkg::*;

   localparam int NoRegs = 16;
   localparam logic [NoRegs-1:0] RoMask = 16'h8008;
   localparam logic [NoRegs-1:0][31:0] RstVals = {
      32'h1000_000F, 32'h1000_000E, 32'h1000_000D, 32'h1000_000C,
      32'h1000_000B, 32'h1000_000A, 32'h1000_0009, 32'h1000_0008,
      32'h1000_0007, 32'h1000_0006, 32'h1000_0005, 32'h1000_0004,
      32'hFFFF_FFFF, 32'hA5A5_0000, 32'h0000_0005, 32'h1000_0000};

   logic clk_i = 1'b0;
   logic rst_i;
   req_t req;
   resp_t resp;
   logic [NoRegs-1:0][31:0] regQ;
   logic [NoRegs-1:0] regWr;
   logic [NoRegs-1:0][31:0] roD;

   logic [31:0] model [NoRegs];
   int checkCount = 0;
   int errorCount = 0;

   axi_lite_reg_slv #(
      .NoRegs      (NoRegs),
      .AxiAddrWidth(32),
      .AxiDataWidth(32),
      .BaseAddr    (32'h0),
      .ReadOnly    (RoMask),
      .RegRstVal   (RstVals),
      .axi_req_t   (req_t),
      .axi_resp_t  (resp_t)
   ) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .slv_req_i (req),
      .slv_resp_o(resp),
      .reg_q_o   (regQ),
      .reg_wr_o  (regWr),
      .ro_d_i    (roD)
   );

   // 10 ns clock
   always #5 clk_i = ~clk_i;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checkCount++;
      if (obs !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Model reset: RW words take their reset value, RO words read as 0 on reg_q_o.
   task automatic modelReset();
      for (int k = 0; k < NoRegs; k++) model[k] = RoMask[k] ? 32'h0 : RstVals[k];
   endtask

   task automatic checkAllRegs(input string tag);
      for (int k = 0; k < NoRegs; k++)
         checkOutput($sformatf("%s_q%0d", tag, k), 64'(regQ[k]), 64'(model[k]));
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Full write transaction with optional B backpressure, checked against the model.
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                                input logic [3:0] strb, input int bHold);
      logic [31:0] word;
      logic hit;
      int idx;
      logic [1:0] expResp;
      logic [NoRegs-1:0] expWr;
      word = addr >> 2;
      hit = word < 32'(NoRegs);
      idx = hit ? int'(word) : 0;
      expWr = '0;
      if (!hit) expResp = 2'b11;
      else if (RoMask[idx]) expResp = 2'b10;
      else begin
         expResp = 2'b00;
         expWr[idx] = 1'b1;
      end
      req.aw.addr = addr;
      req.w.data = data;
      req.w.strb = strb;
      req.aw_valid = 1'b1;
      req.w_valid = 1'b1;
      #1;
      checkOutput("wr_aw_ready", 64'(resp.aw_ready), 64'(1));
      checkOutput("wr_w_ready", 64'(resp.w_ready), 64'(1));
      tick();
      req.aw_valid = 1'b0;
      req.w_valid = 1'b0;
      if (expWr != '0)
         for (int b = 0; b < 4; b++)
            if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
      checkOutput("wr_pulse", 64'(regWr), 64'(expWr));
      checkAllRegs("wr");
      checkOutput("wr_b_valid", 64'(resp.b_valid), 64'(1));
      checkOutput("wr_b_resp", 64'(resp.b.resp), 64'(expResp));
      for (int i = 0; i < bHold; i++) begin
         tick();
         checkOutput("wr_b_hold_valid", 64'(resp.b_valid), 64'(1));
         checkOutput("wr_b_hold_resp", 64'(resp.b.resp), 64'(expResp));
         checkOutput("wr_pulse_gone", 64'(regWr), 64'(0));
      end
      req.b_ready = 1'b1;
      tick();
      req.b_ready = 1'b0;
      checkOutput("wr_b_done", 64'(resp.b_valid), 64'(0));
      checkOutput("wr_pulse_end", 64'(regWr), 64'(0));
   endtask

   // Full read transaction with optional R backpressure.
   task automatic doRead(input logic [31:0] addr, input int rHold);
      logic [31:0] word;
      logic [31:0] expData;
      logic [1:0] expResp;
      int idx;
      word = addr >> 2;
      if (word >= 32'(NoRegs)) begin
         expData = 32'h0;
         expResp = 2'b11;
      end else begin
         idx = int'(word);
         expData = RoMask[idx] ? roD[idx] : model[idx];
         expResp = 2'b00;
      end
      req.ar.addr = addr;
      req.ar_valid = 1'b1;
      #1;
      checkOutput("rd_ar_ready", 64'(resp.ar_ready), 64'(1));
      tick();
      req.ar_valid = 1'b0;
      checkOutput("rd_r_valid", 64'(resp.r_valid), 64'(1));
      checkOutput("rd_data", 64'(resp.r.data), 64'(expData));
      checkOutput("rd_resp", 64'(resp.r.resp), 64'(expResp));
      for (int i = 0; i < rHold; i++) begin
         tick();
         checkOutput("rd_hold_valid", 64'(resp.r_valid), 64'(1));
         checkOutput("rd_hold_data", 64'(resp.r.data), 64'(expData));
         checkOutput("rd_hold_ar_ready", 64'(resp.ar_ready), 64'(0));
      end
      req.r_ready = 1'b1;
      tick();
      req.r_ready = 1'b0;
      checkOutput("rd_done", 64'(resp.r_valid), 64'(0));
   endtask

   initial begin
      logic [31:0] oldVal;
      logic [31:0] addr;
      rst_i = 1'b1;
      req = '0;
      for (int k = 0; k < NoRegs; k++) roD[k] = $urandom;
      roD[3] = 32'hDEAD_BEEF;
      modelReset();

      // Reset state, including readies forced low while valids are high
      repeat (3) @(posedge clk_i);
      #1;
      req.aw_valid = 1'b1;
      req.w_valid = 1'b1;
      #1;
      checkOutput("rst_aw_ready", 64'(resp.aw_ready), 64'(0));
      checkOutput("rst_ar_ready", 64'(resp.ar_ready), 64'(0));
      checkOutput("rst_b_valid", 64'(resp.b_valid), 64'(0));
      checkOutput("rst_r_valid", 64'(resp.r_valid), 64'(0));
      req.aw_valid = 1'b0;
      req.w_valid = 1'b0;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      #1;
      checkOutput("rst_reg2", 64'(regQ[2]), 64'(32'hA5A5_0000));
      checkOutput("rst_reg3_ro", 64'(regQ[3]), 64'(0));
      checkOutput("rst_wr", 64'(regWr), 64'(0));
      checkOutput("rst_b_valid_rel", 64'(resp.b_valid), 64'(0));
      checkOutput("rst_r_valid_rel", 64'(resp.r_valid), 64'(0));
      checkAllRegs("rst");
      tick();

      // Strobed write on reg 2 (cleared first), B held off for 3 cycles
      applyStimulus(32'h08, 32'h0, 4'hF, 0);
      applyStimulus(32'h08, 32'h1122_3344, 4'b0101, 3);
      checkOutput("strb_reg2", 64'(regQ[2]), 64'(32'h0022_0044));
      applyStimulus(32'h08, 32'hFFFF_FFFF, 4'b0000, 0);

      // Read-only and miss handling
      applyStimulus(32'h0C, 32'h1234_5678, 4'hF, 0);
      doRead(32'h40, 0);
      doRead(32'h0C, 0);
      doRead(32'h3F, 1);

      // Backpressure: R held off 5 cycles; AW without W never accepted
      doRead(32'h08, 5);
      req.aw.addr = 32'h04;
      req.aw_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checkOutput("aw_only_ready", 64'(resp.aw_ready), 64'(0));
         checkOutput("aw_only_w_ready", 64'(resp.w_ready), 64'(0));
         tick();
      end
      req.aw_valid = 1'b0;
      checkOutput("aw_only_no_b", 64'(resp.b_valid), 64'(0));

      // Concurrent read and write to reg 1
      applyStimulus(32'h04, 32'h5, 4'hF, 0);
      oldVal = model[1];
      req.ar.addr = 32'h04;
      req.ar_valid = 1'b1;
      req.aw.addr = 32'h04;
      req.w.data = 32'h9;
      req.w.strb = 4'hF;
      req.aw_valid = 1'b1;
      req.w_valid = 1'b1;
      #1;
      checkOutput("cc_ar_ready", 64'(resp.ar_ready), 64'(1));
      checkOutput("cc_aw_ready", 64'(resp.aw_ready), 64'(1));
      tick();
      req.ar_valid = 1'b0;
      req.aw_valid = 1'b0;
      req.w_valid = 1'b0;
      model[1] = 32'h9;
      checkOutput("cc_rdata_old", 64'(resp.r.data), 64'(oldVal));
      checkOutput("cc_reg1_new", 64'(regQ[1]), 64'(32'h9));
      checkOutput("cc_pulse", 64'(regWr), 64'(16'h0002));
      req.b_ready = 1'b1;
      req.r_ready = 1'b1;
      tick();
      req.b_ready = 1'b0;
      req.r_ready = 1'b0;
      checkOutput("cc_b_done", 64'(resp.b_valid), 64'(0));
      checkOutput("cc_r_done", 64'(resp.r_valid), 64'(0));

      // Randomized mix of reads and writes, including misses and RO targets
      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 7) == 0) addr = $urandom | 32'h8000_0000;
         else addr = 32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) roD[$urandom_range(0, NoRegs - 1)] = $urandom;
         if ($urandom_range(0, 1) == 1)
            applyStimulus(addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
         else
            doRead(addr, $urandom_range(0, 2));
      end

      // Asynchronous reset with both responses outstanding
      req.aw.addr = 32'h10;
      req.w.data = 32'hCAFE_F00D;
      req.w.strb = 4'hF;
      req.ar.addr = 32'h14;
      req.aw_valid = 1'b1;
      req.w_valid = 1'b1;
      req.ar_valid = 1'b1;
      tick();
      req.aw_valid = 1'b0;
      req.w_valid = 1'b0;
      req.ar_valid = 1'b0;
      checkOutput("mid_b_valid", 64'(resp.b_valid), 64'(1));
      checkOutput("mid_r_valid", 64'(resp.r_valid), 64'(1));
      #2;
      rst_i = 1'b1;
      #1;
      modelReset();
      checkOutput("mid_rst_b_valid", 64'(resp.b_valid), 64'(0));
      checkOutput("mid_rst_r_valid", 64'(resp.r_valid), 64'(0));
      checkOutput("mid_rst_b_resp", 64'(resp.b.resp), 64'(0));
      checkOutput("mid_rst_r_data", 64'(resp.r.data), 64'(0));
      checkOutput("mid_rst_wr", 64'(regWr), 64'(0));
      checkAllRegs("mid_rst");
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      tick();
      doRead(32'h08, 0);
      doRead(32'h10, 1);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
